norm_scheduler: RTL and testbench
=================================

NORM_SCHEDULER -- requirements
Module: norm_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of accumulator requesters sharing one normalization pipeline (2..8).
REQ-002 The block SHALL have parameter NORM_LAT, default 4, fixed issue-to-result latency of the normalization pipeline in cycles.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester request; held high with payload stable until granted.
REQ-006 req_frac  input  NREQ*128  per-requester 128-bit two's-complement accumulator fraction.
REQ-007 req_blk  input  NREQ*3  per-requester block index.
REQ-008 req_sign, req_inf  input  NREQ each  per-requester sign and infinity flags.
REQ-009 gnt  output  NREQ  one-hot grant pulse; payload consumed in the same cycle.
REQ-010 norm_frac/norm_blk/norm_sign/norm_inf/norm_finish  output  128/3/1/1/1  issue port to the normalization pipeline; norm_finish marks a valid issue.
REQ-011 norm_unum/norm_ovf  input  32/1  result port from the pipeline.
REQ-012 res_valid/res_id/res_unum/res_ovf  output  1/clog2(NREQ)/32/1  routed result to requesters.

Function
REQ-013 The block SHALL grant at most one requester per cycle, using round-robin priority starting at the index after the last granted one; after reset, index 0 has highest priority.
REQ-014 A grant SHALL register the selected payload onto the norm_* outputs and assert norm_finish for exactly one cycle, one cycle after gnt.
REQ-015 Cycles with no request SHALL drive norm_finish=0 and norm_frac=0, norm_blk=0, norm_sign=0, norm_inf=0.
REQ-016 The block SHALL track each issue with a NORM_LAT-deep valid/id shift pipe; res_valid SHALL assert exactly NORM_LAT cycles after norm_finish, carrying that issue's id.
REQ-017 res_unum/res_ovf SHALL equal norm_unum/norm_ovf sampled in the res_valid cycle, combinationally.
REQ-018 The block SHALL ignore the pipeline's own finish signal; result validity comes only from the internal tracking pipe.
REQ-019 Back-to-back grants SHALL be sustained at one per cycle: full throughput, NORM_LAT results in flight.
REQ-020 When a granted requester keeps req high in the following cycle, it SHALL be treated as a new request and ordered by round-robin.
REQ-021 When all requesters request continuously, each SHALL be granted once every NREQ cycles, in index order.
REQ-022 When req_inf is set, norm_inf SHALL pass it through unchanged and the scheduler SHALL not alter res_ovf.

Reset
REQ-023 While rst=1, the block SHALL drive gnt=0, norm_finish=0, all norm_* data outputs 0, res_valid=0 and res_id=0, SHALL clear the tracking pipe, and SHALL set the round-robin pointer to index 0.
REQ-024 Reset mid-operation SHALL discard all in-flight results: no res_valid for any issue made before reset, even though the pipeline datapath itself is not reset.

Configuration
REQ-025 With NORM_SCHED_OVF_SAT_EN defined, a result with norm_ovf=1 and a non-infinity issue SHALL output res_unum=32'h7FFF_FFFF for positive and 32'h8000_0001 for negative, using the sign tracked in the pipe; without the macro, res_unum SHALL pass norm_unum through unmodified.

Structure
REQ-026 A shared package norm_pkg SHALL hold NREQ_DEFAULT, NORM_LAT, FRAC_W=128, UNUM_W=32, BLK_W=3 and the posit saturation constants.
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter (req, ptr -> one-hot gnt, index).

Verification
REQ-028 Single request on requester 2 at cycle 10 -> gnt[2] at 10, norm_finish at 11, res_valid with res_id=2 at 15.
REQ-029 All 4 requesting continuously from reset -> grant order 0,1,2,3,0,…; res_valid is continuously high starting 5 cycles after the first grant.
REQ-030 rst pulsed for 1 cycle with 3 issues in flight -> no res_valid for the next 4 cycles, then normal operation; first grant goes to index 0.
REQ-031 With the macro defined, norm_ovf=1 on a negative issue -> res_unum=32'h8000_0001; without it -> raw norm_unum.
REQ-032 req_inf=1 issue -> norm_inf=1, res_valid asserted with the correct id, res_unum=32'h8000_0000 from the pipeline passed through.

Source files
------------

// File: rtl/norm_scheduler_pkg.sv
// Shared constants for the normalization scheduler slice.
//
// Package norm_pkg holds the default requester count, the fixed latency of
// the normalization pipeline, the datapath widths and the posit saturation
// values used when a result overflows.
package norm_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int NORM_LAT     = 4;
    localparam int FRAC_W       = 128;
    localparam int UNUM_W       = 32;
    localparam int BLK_W        = 3;

    // Largest positive posit and most negative finite posit (NaR is 8000_0000).
    localparam logic [UNUM_W-1:0] POSIT_SAT_POS = 32'h7FFF_FFFF;
    localparam logic [UNUM_W-1:0] POSIT_SAT_NEG = 32'h8000_0001;

    // Saturated result for an overflowed issue of the given sign.
    function automatic logic [UNUM_W-1:0] sat_unum(input logic sign);
        return sign ? POSIT_SAT_NEG : POSIT_SAT_POS;
    endfunction

endpackage

// File: rtl/norm_scheduler_if.sv
// Bundle of requester, pipeline-issue, pipeline-result and routed-result
// signals around the normalization scheduler.
//
// Signals:
//   req / req_frac / req_blk / req_sign / req_inf : requester payloads
//   gnt                                           : one-hot grant pulse
//   norm_frac / norm_blk / norm_sign / norm_inf / norm_finish : issue port
//   norm_unum / norm_ovf                          : pipeline result port
//   res_valid / res_id / res_unum / res_ovf       : routed result
// Modports: slave is the scheduler view, master is the surrounding system.
interface norm_scheduler_if #(
    parameter int NREQ = norm_pkg::NREQ_DEFAULT
);
    import norm_pkg::*;

    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [NREQ*FRAC_W-1:0] req_frac;
    logic [NREQ*BLK_W-1:0]  req_blk;
    logic [NREQ-1:0]        req_sign;
    logic [NREQ-1:0]        req_inf;
    logic [NREQ-1:0]        gnt;

    logic [FRAC_W-1:0]      norm_frac;
    logic [BLK_W-1:0]       norm_blk;
    logic                   norm_sign;
    logic                   norm_inf;
    logic                   norm_finish;

    logic [UNUM_W-1:0]      norm_unum;
    logic                   norm_ovf;

    logic                   res_valid;
    logic [ID_W-1:0]        res_id;
    logic [UNUM_W-1:0]      res_unum;
    logic                   res_ovf;

    modport slave (
        input  req, req_frac, req_blk, req_sign, req_inf, norm_unum, norm_ovf,
        output gnt, norm_frac, norm_blk, norm_sign, norm_inf, norm_finish,
               res_valid, res_id, res_unum, res_ovf
    );

    modport master (
        output req, req_frac, req_blk, req_sign, req_inf, norm_unum, norm_ovf,
        input  gnt, norm_frac, norm_blk, norm_sign, norm_inf, norm_finish,
               res_valid, res_id, res_unum, res_ovf
    );

endinterface

// File: rtl/norm_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr_i,
// wrapping around.
//
// Ports:
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle (must be < NREQ)
//   gnt_o   : one-hot grant
//   idx_o   : index of the granted requester
//   valid_o : a grant was made
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);
    import norm_pkg::*;

    // Scan from the pointer upward; the first hit wins and masks the rest.
    always_comb begin
        int j;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/norm_scheduler.sv
// Normalization scheduler: arbitrates NREQ accumulator requesters onto one
// shared normalization pipeline, registers the winner's payload onto the
// issue port, tracks every issue through a NORM_LAT-deep valid/id pipe and
// routes the pipeline result back tagged with the requester id.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : norm_scheduler_if.slave (requests, grant, issue, result)
//
// Optional feature macro: NORM_SCHED_OVF_SAT_EN
//   When defined, an overflowed non-infinity result is replaced by the
//   saturated posit of the issue's sign. When undefined, res_unum passes
//   norm_unum through unchanged.
module norm_scheduler #(
    parameter int NREQ     = norm_pkg::NREQ_DEFAULT,
    parameter int NORM_LAT = norm_pkg::NORM_LAT
) (
    input  logic            clk,
    input  logic            rst,
    norm_scheduler_if.slave bus
);
    import norm_pkg::*;

    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]   arb_req;
    logic [NREQ-1:0]   arb_gnt;
    logic [ID_W-1:0]   arb_idx;
    logic              arb_valid;

    logic [ID_W-1:0]   ptr_q,    ptr_d;
    logic              finish_q, finish_d;
    logic [FRAC_W-1:0] frac_q,   frac_d;
    logic [BLK_W-1:0]  blk_q,    blk_d;
    logic              sign_q,   sign_d;
    logic              inf_q,    inf_d;
    logic [ID_W-1:0]   id_q,     id_d;

    logic              pipe_v_q  [NORM_LAT];
    logic [ID_W-1:0]   pipe_id_q [NORM_LAT];
`ifdef NORM_SCHED_OVF_SAT_EN
    logic              pipe_sign_q [NORM_LAT];
    logic              pipe_inf_q  [NORM_LAT];
`endif

    logic              res_valid;

    // Requests are masked during reset so no grant escapes in that cycle.
    assign arb_req = rst ? '0 : bus.req;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req_i   (arb_req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Select the winner's payload; idle cycles issue all-zero data. The
    // pointer moves just past the winner so a requester that keeps asking
    // drops to lowest priority.
    always_comb begin
        ptr_d    = ptr_q;
        finish_d = 1'b0;
        frac_d   = '0;
        blk_d    = '0;
        sign_d   = 1'b0;
        inf_d    = 1'b0;
        id_d     = '0;
        if (arb_valid) begin
            ptr_d    = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
            finish_d = 1'b1;
            frac_d   = bus.req_frac[arb_idx*FRAC_W +: FRAC_W];
            blk_d    = bus.req_blk[arb_idx*BLK_W +: BLK_W];
            sign_d   = bus.req_sign[arb_idx];
            inf_d    = bus.req_inf[arb_idx];
            id_d     = arb_idx;
        end
    end

    // Issue register plus tracking pipe. Stage 0 captures the issue visible
    // on norm_finish, so the last stage lines up NORM_LAT cycles later with
    // the pipeline's result. Reset empties the pipe so in-flight results
    // from before reset are never reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            finish_q <= 1'b0;
            frac_q   <= '0;
            blk_q    <= '0;
            sign_q   <= 1'b0;
            inf_q    <= 1'b0;
            id_q     <= '0;
            for (int s = 0; s < NORM_LAT; s++) begin
                pipe_v_q[s]    <= 1'b0;
                pipe_id_q[s]   <= '0;
`ifdef NORM_SCHED_OVF_SAT_EN
                pipe_sign_q[s] <= 1'b0;
                pipe_inf_q[s]  <= 1'b0;
`endif
            end
        end else begin
            ptr_q    <= ptr_d;
            finish_q <= finish_d;
            frac_q   <= frac_d;
            blk_q    <= blk_d;
            sign_q   <= sign_d;
            inf_q    <= inf_d;
            id_q     <= id_d;
            pipe_v_q[0]    <= finish_q;
            pipe_id_q[0]   <= id_q;
`ifdef NORM_SCHED_OVF_SAT_EN
            pipe_sign_q[0] <= sign_q;
            pipe_inf_q[0]  <= inf_q;
`endif
            for (int s = 1; s < NORM_LAT; s++) begin
                pipe_v_q[s]    <= pipe_v_q[s-1];
                pipe_id_q[s]   <= pipe_id_q[s-1];
`ifdef NORM_SCHED_OVF_SAT_EN
                pipe_sign_q[s] <= pipe_sign_q[s-1];
                pipe_inf_q[s]  <= pipe_inf_q[s-1];
`endif
            end
        end
    end

    // Outputs are forced quiet for the whole reset cycle, not just after it.
    assign bus.gnt         = arb_gnt;
    assign bus.norm_finish = finish_q & ~rst;
    assign bus.norm_frac   = rst ? '0 : frac_q;
    assign bus.norm_blk    = rst ? '0 : blk_q;
    assign bus.norm_sign   = sign_q & ~rst;
    assign bus.norm_inf    = inf_q & ~rst;

    assign res_valid     = pipe_v_q[NORM_LAT-1] & ~rst;
    assign bus.res_valid = res_valid;
    assign bus.res_id    = res_valid ? pipe_id_q[NORM_LAT-1] : '0;
    assign bus.res_ovf   = bus.norm_ovf;

`ifdef NORM_SCHED_OVF_SAT_EN
    // Infinity issues keep the pipeline's own encoding even on overflow.
    assign bus.res_unum = (res_valid && bus.norm_ovf && !pipe_inf_q[NORM_LAT-1])
                        ? sat_unum(pipe_sign_q[NORM_LAT-1])
                        : bus.norm_unum;
`else
    assign bus.res_unum = bus.norm_unum;
`endif

endmodule

// File: tb/tb_norm_scheduler.sv
// Self-checking bench for norm_scheduler: directed scenarios with literal
// expectations, plus a cycle-indexed behavioural model that checks every
// output on every cycle.
module tb_norm_scheduler;

    localparam int N    = 4;
    localparam int L    = 4;
    localparam int HIST = 1024;

    logic clk;
    logic rst;

    norm_scheduler_if #(.NREQ(N)) bus ();

    norm_scheduler #(
        .NREQ     (N),
        .NORM_LAT (L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int passCount  = 0;
    int totalCount = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // Drive one cycle's inputs just after the rising edge.
    task automatic applyStimulus(input logic r, input logic [N-1:0] rq,
                                 input logic [31:0] unum, input logic ovf);
        @(posedge clk);
        #1;
        rst           = r;
        bus.req       = rq;
        bus.norm_unum = unum;
        bus.norm_ovf  = ovf;
    endtask

    task automatic setPayload(input int j, input logic [127:0] f, input logic [2:0] b,
                              input logic s, input logic inf);
        bus.req_frac[j*128 +: 128] = f;
        bus.req_blk[j*3 +: 3]      = b;
        bus.req_sign[j]            = s;
        bus.req_inf[j]             = inf;
    endtask

    // Behavioural model: per-cycle history of what the issue port must show.
    // A result is due L cycles after an issue unless reset occurred anywhere
    // in between (inclusive).
    bit           finH  [HIST];
    logic [127:0] fracH [HIST];
    logic [2:0]   blkH  [HIST];
    bit           signH [HIST];
    bit           infH  [HIST];
    bit           rstH  [HIST];
    int           idH   [HIST];

    int           mCyc  = 0;
    int           mPtr  = 0;
    bit           pV    = 1'b0;
    int           pId   = 0;
    logic [127:0] pFrac = '0;
    logic [2:0]   pBlk  = '0;
    bit           pSign = 1'b0;
    bit           pInf  = 1'b0;

    always @(negedge clk) begin : model
        bit           gV;
        int           gId;
        logic [N-1:0] expGnt;
        bit           rv;
        int           k;
        int           j;
        logic [31:0]  expUnum;
        if (mCyc < HIST) begin
            rstH[mCyc] = rst;
            gV = 1'b0;
            gId = 0;
            expGnt = '0;
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    j = (mPtr + i) % N;
                    if (!gV && bus.req[j]) begin
                        gV = 1'b1;
                        gId = j;
                    end
                end
            end
            if (gV) expGnt[gId] = 1'b1;
            checkOutput("gnt", bus.gnt, expGnt);

            finH[mCyc]  = !rst && pV;
            fracH[mCyc] = finH[mCyc] ? pFrac : '0;
            blkH[mCyc]  = finH[mCyc] ? pBlk : '0;
            signH[mCyc] = finH[mCyc] ? pSign : 1'b0;
            infH[mCyc]  = finH[mCyc] ? pInf : 1'b0;
            idH[mCyc]   = finH[mCyc] ? pId : 0;
            checkOutput("norm_finish", bus.norm_finish, finH[mCyc]);
            checkOutput("norm_frac", bus.norm_frac, fracH[mCyc]);
            checkOutput("norm_blk", bus.norm_blk, blkH[mCyc]);
            checkOutput("norm_sign", bus.norm_sign, signH[mCyc]);
            checkOutput("norm_inf", bus.norm_inf, infH[mCyc]);

            rv = 1'b0;
            k = mCyc - L;
            if (k >= 0 && finH[k]) begin
                rv = 1'b1;
                for (int c = k; c <= mCyc; c++) if (rstH[c]) rv = 1'b0;
            end
            checkOutput("res_valid", bus.res_valid, rv);
            checkOutput("res_id", bus.res_id, rv ? idH[k] : 0);
            if (rv) begin
                expUnum = bus.norm_unum;
`ifdef NORM_SCHED_OVF_SAT_EN
                if (bus.norm_ovf && !infH[k]) expUnum = signH[k] ? 32'h8000_0001 : 32'h7FFF_FFFF;
`endif
                checkOutput("res_unum", bus.res_unum, expUnum);
                checkOutput("res_ovf", bus.res_ovf, bus.norm_ovf);
            end

            pV = gV;
            if (gV) begin
                pId   = gId;
                pFrac = bus.req_frac[gId*128 +: 128];
                pBlk  = bus.req_blk[gId*3 +: 3];
                pSign = bus.req_sign[gId];
                pInf  = bus.req_inf[gId];
            end
            if (rst) mPtr = 0;
            else if (gV) mPtr = (gId + 1) % N;
            mCyc++;
        end
    end

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_frac  = '0;
        bus.req_blk   = '0;
        bus.req_sign  = '0;
        bus.req_inf   = '0;
        bus.norm_unum = '0;
        bus.norm_ovf  = 1'b0;

        // Reset state
        repeat (3) applyStimulus(1'b1, '0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("rst_gnt", bus.gnt, 0);
        checkOutput("rst_finish", bus.norm_finish, 0);
        checkOutput("rst_res_valid", bus.res_valid, 0);
        checkOutput("rst_res_id", bus.res_id, 0);

        // Idle issue port is all zero
        repeat (5) applyStimulus(1'b0, '0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("idle_finish", bus.norm_finish, 0);
        checkOutput("idle_frac", bus.norm_frac, 0);

        // Single request on requester 2
        setPayload(2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 3'd5, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0100, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("single_gnt", bus.gnt, 4'b0100);
        applyStimulus(1'b0, '0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("single_finish", bus.norm_finish, 1);
        checkOutput("single_frac", bus.norm_frac, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        checkOutput("single_blk", bus.norm_blk, 3'd5);
        repeat (3) applyStimulus(1'b0, '0, 32'h0, 1'b0);
        applyStimulus(1'b0, '0, 32'h4000_1234, 1'b0);
        @(negedge clk);
        checkOutput("single_res_valid", bus.res_valid, 1);
        checkOutput("single_res_id", bus.res_id, 2);
        checkOutput("single_res_unum", bus.res_unum, 32'h4000_1234);

        // Overflow on a negative issue from requester 1
        setPayload(1, 128'hFFFF_0000_0000_0000_0000_0000_0000_0001, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0010, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("ovf_gnt", bus.gnt, 4'b0010);
        repeat (4) applyStimulus(1'b0, '0, 32'h0, 1'b0);
        applyStimulus(1'b0, '0, 32'h1234_5678, 1'b1);
        @(negedge clk);
        checkOutput("ovf_res_valid", bus.res_valid, 1);
        checkOutput("ovf_res_id", bus.res_id, 1);
`ifdef NORM_SCHED_OVF_SAT_EN
        checkOutput("ovf_res_unum", bus.res_unum, 32'h8000_0001);
`else
        checkOutput("ovf_res_unum", bus.res_unum, 32'h1234_5678);
`endif
        checkOutput("ovf_res_ovf", bus.res_ovf, 1);

        // Infinity issue from requester 3
        setPayload(3, 128'h0, 3'd7, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'b1000, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("inf_gnt", bus.gnt, 4'b1000);
        applyStimulus(1'b0, '0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("inf_norm_inf", bus.norm_inf, 1);
        repeat (3) applyStimulus(1'b0, '0, 32'h0, 1'b0);
        applyStimulus(1'b0, '0, 32'h8000_0000, 1'b1);
        @(negedge clk);
        checkOutput("inf_res_valid", bus.res_valid, 1);
        checkOutput("inf_res_id", bus.res_id, 3);
        checkOutput("inf_res_unum", bus.res_unum, 32'h8000_0000);

        // All four requesting continuously from reset
        applyStimulus(1'b1, '0, 32'h0, 1'b0);
        setPayload(0, 128'hA0A0_0000_0000_0000_0000_0000_0000_000A, 3'd0, 1'b0, 1'b0);
        setPayload(1, 128'hB1B1_0000_0000_0000_0000_0000_0000_001B, 3'd1, 1'b1, 1'b0);
        setPayload(2, 128'hC2C2_0000_0000_0000_0000_0000_0000_002C, 3'd2, 1'b0, 1'b1);
        setPayload(3, 128'hD3D3_0000_0000_0000_0000_0000_0000_003D, 3'd3, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 4'b1111, $urandom, 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (i < 5) checkOutput("cont_gnt", bus.gnt, 4'b0001 << (i % 4));
            if (i == 5) begin
                checkOutput("cont_res_valid", bus.res_valid, 1);
                checkOutput("cont_res_id", bus.res_id, 0);
            end
        end

        // Reset mid-operation with issues in flight
        applyStimulus(1'b1, 4'b1111, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("midrst_gnt", bus.gnt, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b1111, $urandom, 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (i == 0) checkOutput("midrst_first_gnt", bus.gnt, 4'b0001);
            checkOutput("midrst_res_valid", bus.res_valid, 0);
        end
        repeat (8) applyStimulus(1'b0, 4'b1111, $urandom, 1'($urandom_range(0, 1)));
        repeat (8) applyStimulus(1'b0, '0, $urandom, 1'($urandom_range(0, 1)));
        @(negedge clk);
        #1;
        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
